// File: rtl/div_sqrt_rec_fn_excq.sv
// Issue/response wrapper around a non-pipelined recoded-float div/sqrt core:
// one op in flight, result FIFO with micro-flag classification and watchdog.
// Optional sticky micro-flag accumulator enabled by define DIVSQRT_STICKY_EN.
module div_sqrt_rec_fn_excq #(
    parameter int EXP_W     = 11,
    parameter int SIG_W     = 53,
    parameter int TAG_W     = 5,
    parameter int OUT_DEPTH = 2,
    parameter int TIMEOUT   = 64,
    localparam int RW       = EXP_W + SIG_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic             io_req_sqrt,
    input  logic [RW-1:0]    io_req_a,
    input  logic [RW-1:0]    io_req_b,
    input  logic [2:0]       io_req_rm,
    input  logic [TAG_W-1:0] io_req_tag,
    input  logic [3:0]       io_req_isSNaN,
    input  logic [6:0]       io_req_exc_enabled,
    output logic             core_inValid,
    input  logic             core_inReady_div,
    input  logic             core_inReady_sqrt,
    output logic             core_sqrtOp,
    output logic [RW-1:0]    core_a,
    output logic [RW-1:0]    core_b,
    output logic [2:0]       core_rm,
    input  logic             core_outValid_div,
    input  logic             core_outValid_sqrt,
    input  logic [RW-1:0]    core_out,
    input  logic [4:0]       core_flags,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [TAG_W-1:0] io_resp_tag,
    output logic [RW-1:0]    io_resp_out,
    output logic [4:0]       io_resp_flags,
    output logic [9:0]       io_resp_u_flag,
    output logic [6:0]       io_resp_u_exception,
    output logic             io_resp_timeout,
    output logic             io_busy
`ifdef DIVSQRT_STICKY_EN
    ,
    output logic [9:0]       io_sticky_u_flag,
    input  logic             io_sticky_clear
`endif
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q;
    logic [WW-1:0]    wd_q;
    logic [TAG_W-1:0] tag_q;
    logic             sqrt_q;
    logic [3:0]       snan_q;
    logic [6:0]       exc_q;
    logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
    logic [CW-1:0]    cnt_q;

    logic [TAG_W-1:0] tag_mem   [OUT_DEPTH];
    logic [RW-1:0]    out_mem   [OUT_DEPTH];
    logic [4:0]       flags_mem [OUT_DEPTH];
    logic [9:0]       uf_mem    [OUT_DEPTH];
    logic [6:0]       ue_mem    [OUT_DEPTH];
    logic             to_mem    [OUT_DEPTH];

    logic has_room, fire, match, wd_expired, push, pop;

    assign has_room   = cnt_q < CW'(OUT_DEPTH);
    assign io_req_ready = ~reset && state_q == S_IDLE && has_room &&
                          (io_req_sqrt ? core_inReady_sqrt : core_inReady_div);
    assign core_inValid = ~reset && state_q == S_IDLE && has_room && io_req_valid;
    assign fire       = io_req_valid & io_req_ready;
    assign match      = state_q == S_WAIT && (sqrt_q ? core_outValid_sqrt : core_outValid_div);
    assign wd_expired = state_q == S_WAIT && wd_q == WW'(TIMEOUT - 1);
    assign push       = match | wd_expired;
    assign pop        = io_resp_valid & io_resp_ready;

    assign core_sqrtOp = io_req_sqrt;
    assign core_a      = io_req_a;
    assign core_b      = io_req_b;
    assign core_rm     = io_req_rm;
    assign io_busy     = state_q == S_WAIT;

    assign wr_d = (wr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    assign rd_d = (rd_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_q + PW'(1);

    // Result classification from the recoded exponent and the latched operand info
    logic [EXP_W:0] res_exp;
    logic           is_zero, r_inf, c_invalid, c_sub, c_inexact;

    assign res_exp   = core_out[RW-2 -: EXP_W+1];
    assign is_zero   = res_exp[EXP_W -: 3] == 3'b000;
    assign r_inf     = (res_exp[EXP_W -: 2] == 2'b11) & ~res_exp[EXP_W-2];
    assign c_invalid = snan_q[0] | snan_q[1] | core_flags[4];
    assign c_sub     = snan_q[2] | snan_q[3];
    assign c_inexact = core_flags[0] & ~c_invalid;

    logic [RW-1:0] push_out;
    logic [4:0]    push_flags;
    logic [9:0]    push_uf;
    logic [6:0]    push_ue;
    logic          push_to;

    // A real completion wins over a watchdog expiry in the same cycle
    always_comb begin
        push_out   = '0;
        push_flags = 5'b10000;
        push_uf    = 10'h004;
        push_ue    = 7'h40 & exc_q;
        push_to    = 1'b1;
        if (match) begin
            push_out   = core_out;
            push_flags = core_flags;
            push_uf    = {core_flags[3], 1'b0, c_sub, 1'b0, c_inexact, core_flags[2],
                          core_flags[1], c_invalid, r_inf, is_zero};
            push_ue    = {c_invalid, core_flags[3], core_flags[2], core_flags[1],
                          c_inexact, 1'b0, c_sub} & exc_q;
            push_to    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            tag_q   <= '0;
            sqrt_q  <= 1'b0;
            snan_q  <= '0;
            exc_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire) begin
                        state_q <= S_WAIT;
                        wd_q    <= '0;
                        tag_q   <= io_req_tag;
                        sqrt_q  <= io_req_sqrt;
                        snan_q  <= io_req_isSNaN;
                        exc_q   <= io_req_exc_enabled;
                    end
                end
                S_WAIT: begin
                    if (push) state_q <= S_IDLE;
                    else      wd_q    <= wd_q + WW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            if (push) wr_q <= wr_d;
            if (pop)  rd_q <= rd_d;
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_q]   <= tag_q;
            out_mem[wr_q]   <= push_out;
            flags_mem[wr_q] <= push_flags;
            uf_mem[wr_q]    <= push_uf;
            ue_mem[wr_q]    <= push_ue;
            to_mem[wr_q]    <= push_to;
        end
    end

    assign io_resp_valid       = cnt_q != '0;
    assign io_resp_tag         = io_resp_valid ? tag_mem[rd_q]   : '0;
    assign io_resp_out         = io_resp_valid ? out_mem[rd_q]   : '0;
    assign io_resp_flags       = io_resp_valid ? flags_mem[rd_q] : '0;
    assign io_resp_u_flag      = io_resp_valid ? uf_mem[rd_q]    : '0;
    assign io_resp_u_exception = io_resp_valid ? ue_mem[rd_q]    : '0;
    assign io_resp_timeout     = io_resp_valid ? to_mem[rd_q]    : 1'b0;

`ifdef DIVSQRT_STICKY_EN
    logic [9:0] sticky_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                sticky_q <= '0;
        else if (io_sticky_clear) sticky_q <= push ? push_uf : '0;
        else if (push)            sticky_q <= sticky_q | push_uf;
    end

    assign io_sticky_u_flag = sticky_q;
`endif

endmodule

// File: tb/tb_div_sqrt_rec_fn_excq.sv
// Directed + randomized bench for div_sqrt_rec_fn_excq; the bench plays the core
// and predicts every response from the classification rules.
module tb_div_sqrt_rec_fn_excq;

    localparam int EXP_W = 11;
    localparam int SIG_W = 53;
    localparam int TAG_W = 5;
    localparam int D     = 2;
    localparam int T     = 64;
    localparam int RW    = EXP_W + SIG_W + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_req_valid = 1'b0, io_req_ready, io_req_sqrt = 1'b0;
    logic [RW-1:0]    io_req_a = '0, io_req_b = '0;
    logic [2:0]       io_req_rm = '0;
    logic [TAG_W-1:0] io_req_tag = '0;
    logic [3:0]       io_req_isSNaN = '0;
    logic [6:0]       io_req_exc_enabled = '0;
    logic             core_inValid, core_sqrtOp;
    logic             core_inReady_div = 1'b1, core_inReady_sqrt = 1'b1;
    logic [RW-1:0]    core_a, core_b;
    logic [2:0]       core_rm;
    logic             core_outValid_div = 1'b0, core_outValid_sqrt = 1'b0;
    logic [RW-1:0]    core_out = '0;
    logic [4:0]       core_flags = '0;
    logic             io_resp_valid, io_resp_ready = 1'b0;
    logic [TAG_W-1:0] io_resp_tag;
    logic [RW-1:0]    io_resp_out;
    logic [4:0]       io_resp_flags;
    logic [9:0]       io_resp_u_flag;
    logic [6:0]       io_resp_u_exception;
    logic             io_resp_timeout, io_busy;
`ifdef DIVSQRT_STICKY_EN
    logic [9:0]       io_sticky_u_flag;
    logic             io_sticky_clear = 1'b0;
`endif

    div_sqrt_rec_fn_excq #(.EXP_W(EXP_W), .SIG_W(SIG_W), .TAG_W(TAG_W),
                           .OUT_DEPTH(D), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_sqrt(io_req_sqrt), .io_req_a(io_req_a), .io_req_b(io_req_b),
        .io_req_rm(io_req_rm), .io_req_tag(io_req_tag),
        .io_req_isSNaN(io_req_isSNaN), .io_req_exc_enabled(io_req_exc_enabled),
        .core_inValid(core_inValid), .core_inReady_div(core_inReady_div),
        .core_inReady_sqrt(core_inReady_sqrt), .core_sqrtOp(core_sqrtOp),
        .core_a(core_a), .core_b(core_b), .core_rm(core_rm),
        .core_outValid_div(core_outValid_div), .core_outValid_sqrt(core_outValid_sqrt),
        .core_out(core_out), .core_flags(core_flags),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_tag(io_resp_tag), .io_resp_out(io_resp_out),
        .io_resp_flags(io_resp_flags), .io_resp_u_flag(io_resp_u_flag),
        .io_resp_u_exception(io_resp_u_exception), .io_resp_timeout(io_resp_timeout),
        .io_busy(io_busy)
`ifdef DIVSQRT_STICKY_EN
        , .io_sticky_u_flag(io_sticky_u_flag), .io_sticky_clear(io_sticky_clear)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [RW-1:0]    out;
        logic [4:0]       flags;
        logic [9:0]       uf;
        logic [6:0]       ue;
        logic             to;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    logic             cur_sqrt;
    logic [3:0]       cur_snan;
    logic [6:0]       cur_exc;
    logic [TAG_W-1:0] cur_tag;

    task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: IEEE flags {inv,div0,ovf,unf,inx}; recoded exponent top bits decide zero/inf
    function automatic exp_t model(input logic [RW-1:0] out, input logic [4:0] fl);
        exp_t e;
        int unsigned ex   = out[RW-2 -: EXP_W+1];
        int zero = ((ex >> (EXP_W - 2)) == 0) ? 1 : 0;
        int inf  = ((ex >> (EXP_W - 1)) == 3 && ((ex >> (EXP_W - 2)) % 2) == 0) ? 1 : 0;
        int inv  = (cur_snan[0] || cur_snan[1] || fl[4]) ? 1 : 0;
        int sub  = (cur_snan[2] || cur_snan[3]) ? 1 : 0;
        int inx  = (fl[0] && inv == 0) ? 1 : 0;
        int dz   = fl[3] ? 1 : 0;
        int ov   = fl[2] ? 1 : 0;
        int un   = fl[1] ? 1 : 0;
        e.tag   = cur_tag;
        e.out   = out;
        e.flags = fl;
        e.uf    = 10'(dz * 512 + sub * 128 + inx * 32 + ov * 16 + un * 8 + inv * 4 + inf * 2 + zero);
        e.ue    = 7'(inv * 64 + dz * 32 + ov * 16 + un * 8 + inx * 4 + sub) & cur_exc;
        e.to    = 1'b0;
        return e;
    endfunction

    function automatic exp_t model_timeout();
        exp_t e;
        e.tag = cur_tag; e.out = '0; e.flags = 5'b10000;
        e.uf = 10'h004; e.ue = 7'h40 & cur_exc; e.to = 1'b1;
        return e;
    endfunction

    task automatic issue(input logic s, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [3:0] snan, input logic [6:0] exc);
        int n = 0;
        io_req_valid = 1'b1; io_req_sqrt = s; io_req_a = a; io_req_b = b;
        io_req_tag = tag; io_req_isSNaN = snan; io_req_exc_enabled = exc;
        io_req_rm = 3'($urandom);
        #1;
        while (!io_req_ready && n < 50) begin
            @(negedge clock); #1; n++;
        end
        chk("issue_ready", {79'd0, io_req_ready}, 80'd1);
        chk("core_inValid", {79'd0, core_inValid}, 80'd1);
        chk("core_a", 80'(core_a), 80'(a));
        chk("core_b", 80'(core_b), 80'(b));
        chk("core_op_rm", {76'd0, core_sqrtOp, core_rm}, {76'd0, s, io_req_rm});
        cur_sqrt = s; cur_snan = snan; cur_exc = exc; cur_tag = tag;
        @(negedge clock);
        io_req_valid = 1'b0;
        #1;
        chk("busy_after_issue", {79'd0, io_busy}, 80'd1);
        chk("ready_in_wait", {79'd0, io_req_ready}, 80'd1 - 80'd1);
    endtask

    // Drive the core's completion pulse after 'delay' cycles, optionally preceded by a wrong-op pulse
    task automatic complete(input int delay, input bit stray,
                            input logic [RW-1:0] out, input logic [4:0] fl);
        for (int i = 0; i < delay; i++) begin
            core_outValid_div  = (stray && i == 0) ?  cur_sqrt : 1'b0;
            core_outValid_sqrt = (stray && i == 0) ? ~cur_sqrt : 1'b0;
            @(negedge clock);
        end
        core_outValid_div  = ~cur_sqrt;
        core_outValid_sqrt =  cur_sqrt;
        core_out = out; core_flags = fl;
        q.push_back(model(out, fl));
        @(negedge clock);
        core_outValid_div = 1'b0; core_outValid_sqrt = 1'b0;
        #1;
        chk("busy_after_done", {79'd0, io_busy}, 80'd0);
    endtask

    task automatic chk_head();
        exp_t e;
        if (q.size() == 0) begin
            chk("model_queue_empty", 80'd0, 80'd1);
            return;
        end
        e = q[0];
        chk("resp_valid", {79'd0, io_resp_valid}, 80'd1);
        chk("resp_tag", 80'(io_resp_tag), 80'(e.tag));
        chk("resp_out", 80'(io_resp_out), 80'(e.out));
        chk("resp_flags", 80'(io_resp_flags), 80'(e.flags));
        chk("resp_u_flag", 80'(io_resp_u_flag), 80'(e.uf));
        chk("resp_u_exc", 80'(io_resp_u_exception), 80'(e.ue));
        chk("resp_timeout", {79'd0, io_resp_timeout}, {79'd0, e.to});
    endtask

    task automatic expect_pop();
        chk_head();
        io_resp_ready = 1'b1;
        @(negedge clock);
        io_resp_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        #1;
    endtask

    function automatic logic [RW-1:0] rand_rec();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        logic [RW-1:0] one, pinf, qnan, r;
        bit ok;
        one  = {1'b0, 12'h800, 52'd0};
        pinf = {1'b0, 12'hC00, 52'd0};
        qnan = {1'b0, 12'hE00, 52'd1};

        // reset state, with the core ready so gating by reset is visible
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_ready", {79'd0, io_req_ready}, 80'd0);
        chk("rst_busy", {79'd0, io_busy}, 80'd0);
        chk("rst_resp_valid", {79'd0, io_resp_valid}, 80'd0);
        chk("rst_resp_data", {io_resp_tag, io_resp_flags, io_resp_u_flag, io_resp_u_exception,
                              io_resp_timeout}, 80'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {79'd0, io_req_ready}, 80'd1);

        // 1.0 / 0 -> +inf, div-by-zero
        issue(1'b0, one, '0, 5'd3, 4'b0000, 7'h7F);
        complete(3, 1'b0, pinf, 5'b01000);
        chk("div0_u_flag", 80'(io_resp_u_flag), 80'h202);
        chk("div0_u_exc", 80'(io_resp_u_exception), 80'h20);
        expect_pop();

        // sqrt of signalling NaN: invalid raised, inexact suppressed
        issue(1'b1, qnan, '0, 5'd7, 4'b0001, 7'h7F);
        complete(2, 1'b0, qnan, 5'b00001);
        chk("snan_u_flag", 80'(io_resp_u_flag), 80'h004);
        chk("snan_u_exc", 80'(io_resp_u_exception), 80'h40);
        expect_pop();

`ifdef DIVSQRT_STICKY_EN
        chk("sticky_accum", 80'(io_sticky_u_flag), 80'h206);
        io_sticky_clear = 1'b1;
        @(negedge clock);
        io_sticky_clear = 1'b0;
        #1;
        chk("sticky_clear", 80'(io_sticky_u_flag), 80'h000);
`endif

        // randomized ops, some with a wrong-op pulse that must be ignored
        for (int k = 0; k < 24; k++) begin
            r = rand_rec();
            issue(1'($urandom), rand_rec(), rand_rec(), 5'($urandom),
                  ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0, 7'($urandom));
            complete(int'($urandom_range(T - 2)), 1'($urandom), r, 5'($urandom));
            expect_pop();
        end

        // match on the watchdog's last cycle is a normal completion
        issue(1'b0, one, one, 5'd9, 4'd0, 7'h7F);
        complete(T - 1, 1'b0, one, 5'b00000);
        chk("late_match_not_timeout", {79'd0, io_resp_timeout}, 80'd0);
        expect_pop();

        // FIFO full backpressure and in-order drain
        for (int k = 0; k < D; k++) begin
            issue(1'($urandom), rand_rec(), rand_rec(), 5'(16 + k), 4'd0, 7'($urandom));
            complete(int'($urandom_range(4)), 1'b0, rand_rec(), 5'($urandom));
        end
        io_req_valid = 1'b1;
        #1;
        chk("full_req_ready", {79'd0, io_req_ready}, 80'd0);
        chk("full_core_inValid", {79'd0, core_inValid}, 80'd0);
        chk_head();
        io_resp_ready = 1'b1;
        @(negedge clock);
        io_resp_ready = 1'b0;
        io_req_valid  = 1'b0;
        void'(q.pop_front());
        #1;
        chk("ready_after_pop", {79'd0, io_req_ready}, 80'd1);
        for (int k = 1; k < D; k++) expect_pop();
        chk("drained", {79'd0, io_resp_valid}, 80'd0);

        // watchdog: no pulse at all
        issue(1'b1, rand_rec(), '0, 5'd21, 4'd0, 7'h55);
        ok = 1'b1;
        repeat (T - 1) begin
            @(negedge clock); #1;
            if (!io_busy) ok = 1'b0;
        end
        chk("wd_still_busy", {79'd0, ok}, 80'd1);
        @(negedge clock); #1;
        chk("wd_busy_drop", {79'd0, io_busy}, 80'd0);
        q.push_back(model_timeout());
        expect_pop();
        core_outValid_div = 1'b1;
        @(negedge clock);
        core_outValid_div = 1'b0;
        @(negedge clock); #1;
        chk("stray_ignored", {78'd0, io_resp_valid, io_busy}, 80'd0);

        // reset while busy with one result buffered
        issue(1'b0, one, one, 5'd11, 4'd0, 7'h7F);
        complete(1, 1'b0, one, 5'b00001);
        issue(1'b0, one, one, 5'd12, 4'd0, 7'h7F);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {79'd0, io_busy}, 80'd0);
        chk("mid_rst_valid", {79'd0, io_resp_valid}, 80'd0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        issue(1'b1, one, '0, 5'd30, 4'b0100, 7'h7F);
        complete(2, 1'b0, one, 5'b00010);
        expect_pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
